// File: rtl/jpeg_pkg.sv
// Shared JPEG back-end definitions: MCU geometry, default pixel width and the
// output-scheduler state encoding.
package jpeg_pkg;

    localparam int unsigned MCU_S_444 = 8;
    localparam int unsigned MCU_S_411 = 16;
    localparam int unsigned PIX_W_DEF = 24;

    typedef enum logic [2:0] {
        StIdle,
        StLim,
        StRow,
        StRd,
        StWr,
        StDone
    } out_state_e;

    // Visible extent of an MCU along one axis: min(s, lim - off), or 0 when the
    // MCU starts at or beyond the image edge.
    function automatic logic [4:0] clip_dim(input logic [4:0]  s,
                                            input logic [15:0] lim,
                                            input logic [16:0] off);
        logic [17:0] l;
        logic [17:0] o;
        logic [17:0] d;
        l = {2'b00, lim};
        o = {1'b0, off};
        d = l - o;
        if (l <= o) begin
            return 5'd0;
        end else if (d >= {13'd0, s}) begin
            return s;
        end else begin
            return 5'(d);
        end
    endfunction

endpackage

// File: rtl/jpeg_out_skid.sv
// Two-entry valid/ready skid FIFO for the prefetching output path; only built
// when JPEG_OUT_PREFETCH_EN is defined. The producer tracks space via count.
`ifdef JPEG_OUT_PREFETCH_EN
module jpeg_out_skid #(
    parameter int unsigned W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push;
    logic         pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = rd_ptr_q ? ent1_q : ent0_q;
    assign count     = cnt_q;
    assign push      = in_valid && (cnt_q != 2'd2);
    assign pop       = out_valid && out_ready;

    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            if (wr_ptr_q) begin
                ent1_d = in_data;
            end else begin
                ent0_d = in_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/jpeg_out_sched.sv
// Walks the MCU RGB buffer in raster order and writes visible pixels to the
// frame buffer. Define JPEG_OUT_PREFETCH_EN for the one-pixel-per-cycle path.
module jpeg_out_sched
    import jpeg_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned PIX_W  = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mcu_start,
    input  logic              pic_is_411,
    input  logic [15:0]       width,
    input  logic [15:0]       heigth,
    input  logic [12:0]       x_mcu_rgb,
    input  logic [12:0]       y_mcu_rgb,
    output logic              out_empty,
    output logic              buf_rd_en,
    output logic [7:0]        buf_rd_addr,
    input  logic [PIX_W-1:0]  buf_rd_data,
    output logic              fb_wr_valid,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [PIX_W-1:0]  fb_wr_data,
    input  logic              fb_wr_ready
);

    out_state_e        state_q, state_d;
    logic              out_empty_q, out_empty_d;
    logic [4:0]        s_q, s_d;
    logic [12:0]       x_q, x_d;
    logic [12:0]       y_q, y_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [4:0]        cols_q, cols_d;
    logic [4:0]        rows_q, rows_d;
    logic [4:0]        r_q, r_d;
    logic [4:0]        c_q, c_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic [16:0]       x_off;
    logic [16:0]       y_off;
    logic [ADDR_W-1:0] row_prod;

    assign out_empty   = out_empty_q;
    assign x_off       = {4'd0, x_q} * {12'd0, s_q};
    assign y_off       = {4'd0, y_q} * {12'd0, s_q};
    // Unsigned product, truncated so frame-buffer addresses wrap.
    assign row_prod    = ADDR_W'(({23'd0, y_off} + {35'd0, r_q}) * {24'd0, width_q}
                                 + {23'd0, x_off});
    assign buf_rd_addr = 8'(r_q) * 8'(s_q) + 8'(c_q);

`ifdef JPEG_OUT_PREFETCH_EN
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              rd_done_q, rd_done_d;
    logic [1:0]        skid_cnt;
    logic              can_issue;
    logic              pop;

    assign pop = fb_wr_valid && fb_wr_ready;
    // A read may only be issued if its data will have a slot when it lands.
    assign can_issue = !rd_done_q && (pop || (({1'b0, skid_cnt} + {2'd0, pend_q}) < 3'd2));

    jpeg_out_skid #(
        .W(ADDR_W + PIX_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (pend_q),
        .in_data  ({pend_addr_q, buf_rd_data}),
        .out_valid(fb_wr_valid),
        .out_ready(fb_wr_ready),
        .out_data ({fb_wr_addr, fb_wr_data}),
        .count    (skid_cnt)
    );
`else
    logic              wr_first_q, wr_first_d;
    logic [PIX_W-1:0]  data_q, data_d;

    assign fb_wr_addr = row_base_q + ADDR_W'(c_q);
    // Read data is only valid in the first write cycle; hold a copy after that.
    assign fb_wr_data = wr_first_q ? buf_rd_data : data_q;
`endif

    always_comb begin
        state_d     = state_q;
        out_empty_d = out_empty_q;
        s_d         = s_q;
        x_d         = x_q;
        y_d         = y_q;
        width_d     = width_q;
        height_d    = height_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        r_d         = r_q;
        c_d         = c_q;
        row_base_d  = row_base_q;
        buf_rd_en   = 1'b0;
`ifdef JPEG_OUT_PREFETCH_EN
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        rd_done_d   = rd_done_q;
`else
        fb_wr_valid = 1'b0;
        wr_first_d  = 1'b0;
        data_d      = data_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mcu_start) begin
                    s_d         = pic_is_411 ? 5'(MCU_S_411) : 5'(MCU_S_444);
                    x_d         = x_mcu_rgb;
                    y_d         = y_mcu_rgb;
                    width_d     = width;
                    height_d    = heigth;
                    out_empty_d = 1'b0;
                    state_d     = StLim;
                end
            end
            StLim: begin
                cols_d = clip_dim(s_q, width_q, x_off);
                rows_d = clip_dim(s_q, height_q, y_off);
                r_d    = 5'd0;
                c_d    = 5'd0;
`ifdef JPEG_OUT_PREFETCH_EN
                rd_done_d = 1'b0;
`endif
                state_d = (cols_d == 5'd0 || rows_d == 5'd0) ? StDone : StRow;
            end
            StRow: begin
                row_base_d = row_prod;
                state_d    = StRd;
            end
`ifdef JPEG_OUT_PREFETCH_EN
            StRd: begin
                if (can_issue) begin
                    buf_rd_en   = 1'b1;
                    pend_d      = 1'b1;
                    pend_addr_d = row_base_q + ADDR_W'(c_q);
                    if (c_q + 5'd1 != cols_q) begin
                        c_d = c_q + 5'd1;
                    end else begin
                        c_d = 5'd0;
                        if (r_q + 5'd1 != rows_q) begin
                            r_d        = r_q + 5'd1;
                            row_base_d = row_base_q + ADDR_W'(width_q);
                        end else begin
                            rd_done_d = 1'b1;
                        end
                    end
                end
                if (rd_done_q && !pend_q && skid_cnt == 2'd0) begin
                    state_d = StDone;
                end
            end
`else
            StRd: begin
                buf_rd_en  = 1'b1;
                wr_first_d = 1'b1;
                state_d    = StWr;
            end
            StWr: begin
                fb_wr_valid = 1'b1;
                if (wr_first_q) begin
                    data_d = buf_rd_data;
                end
                if (fb_wr_ready) begin
                    if (c_q + 5'd1 != cols_q) begin
                        c_d     = c_q + 5'd1;
                        state_d = StRd;
                    end else if (r_q + 5'd1 != rows_q) begin
                        c_d     = 5'd0;
                        r_d     = r_q + 5'd1;
                        state_d = StRow;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
`endif
            StDone: begin
                out_empty_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_empty_q <= 1'b1;
            s_q         <= 5'd0;
            x_q         <= '0;
            y_q         <= '0;
            width_q     <= '0;
            height_q    <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
            row_base_q  <= '0;
`ifdef JPEG_OUT_PREFETCH_EN
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            rd_done_q   <= 1'b0;
`else
            wr_first_q  <= 1'b0;
            data_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_empty_q <= out_empty_d;
            s_q         <= s_d;
            x_q         <= x_d;
            y_q         <= y_d;
            width_q     <= width_d;
            height_q    <= height_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            r_q         <= r_d;
            c_q         <= c_d;
            row_base_q  <= row_base_d;
`ifdef JPEG_OUT_PREFETCH_EN
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            rd_done_q   <= rd_done_d;
`else
            wr_first_q  <= wr_first_d;
            data_q      <= data_d;
`endif
        end
    end

endmodule

// File: tb/tb_jpeg_out_sched.sv
// Randomised scoreboard bench for jpeg_out_sched: a raster/clip reference model
// queues expected frame-buffer writes, a monitor pops them on each handshake.
module tb_jpeg_out_sched;

    localparam int ADDR_W = 24;
    localparam int PIX_W  = 24;
`ifdef JPEG_OUT_PREFETCH_EN
    localparam int FULL_MCU_CYCLES = 80;
`else
    localparam int FULL_MCU_CYCLES = 140;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mcu_start = 1'b0;
    logic              pic_is_411 = 1'b0;
    logic [15:0]       width = '0;
    logic [15:0]       heigth = '0;
    logic [12:0]       x_mcu_rgb = '0;
    logic [12:0]       y_mcu_rgb = '0;
    logic              out_empty;
    logic              buf_rd_en;
    logic [7:0]        buf_rd_addr;
    logic [PIX_W-1:0]  buf_rd_data = '0;
    logic              fb_wr_valid;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [PIX_W-1:0]  fb_wr_data;
    logic              fb_wr_ready = 1'b1;

    jpeg_out_sched #(
        .ADDR_W(ADDR_W),
        .PIX_W (PIX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mcu_start  (mcu_start),
        .pic_is_411 (pic_is_411),
        .width      (width),
        .heigth     (heigth),
        .x_mcu_rgb  (x_mcu_rgb),
        .y_mcu_rgb  (y_mcu_rgb),
        .out_empty  (out_empty),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data),
        .fb_wr_valid(fb_wr_valid),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_wr_ready(fb_wr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_t;

    wr_t              sb[$];
    logic [PIX_W-1:0] mem[256];
    int               checks = 0;
    int               errors = 0;
    int               acc_cnt = 0;
    int               exp_n = 0;
    int               rmode = 0;
    int               stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous buffer: data valid one cycle after the strobe, noise otherwise.
    always @(posedge clk) begin
        buf_rd_data <= buf_rd_en ? mem[buf_rd_addr] : PIX_W'($urandom);
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: fb_wr_ready = 1'b1;
            1: fb_wr_ready = ($urandom_range(0, 9) < 7);
            default: begin
                if (acc_cnt == 3 && stall_left > 0) begin
                    fb_wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    fb_wr_ready = 1'b1;
                end
            end
        endcase
    end

    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [PIX_W-1:0]  prev_data;
    wr_t               mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mcu_start && !out_empty) begin
                errors++;
                $display("FAIL protocol: mcu_start while busy at %0t", $time);
            end
            if (prev_stall) begin
                check("hold_valid", 64'(fb_wr_valid), 64'd1);
                check("hold_addr", 64'(fb_wr_addr), 64'(prev_addr));
                check("hold_data", 64'(fb_wr_data), 64'(prev_data));
            end
            if (fb_wr_valid && fb_wr_ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                             fb_wr_addr, fb_wr_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", 64'(fb_wr_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(fb_wr_data), 64'(mon_e.data));
                end
            end
            prev_stall = fb_wr_valid && !fb_wr_ready;
            prev_addr  = fb_wr_addr;
            prev_data  = fb_wr_data;
        end
    end

    task automatic start_mcu(input bit is411, input int w, input int h, input int x,
                             input int y, input int mode);
        int          s;
        longint      px;
        longint      py;
        logic [63:0] a;
        wr_t         e;
        s = is411 ? 16 : 8;
        for (int i = 0; i < 256; i++) mem[i] = PIX_W'($urandom);
        exp_n = 0;
        for (int r = 0; r < s; r++) begin
            for (int c = 0; c < s; c++) begin
                px = longint'(x) * s + c;
                py = longint'(y) * s + r;
                if (px < w && py < h) begin
                    a      = 64'(py * w + px);
                    e.addr = a[ADDR_W-1:0];
                    e.data = mem[r * s + c];
                    sb.push_back(e);
                    exp_n++;
                end
            end
        end
        rmode      = mode;
        stall_left = 5;
        acc_cnt    = 0;
        @(posedge clk);
        #1;
        pic_is_411 = is411;
        width      = 16'(w);
        heigth     = 16'(h);
        x_mcu_rgb  = 13'(x);
        y_mcu_rgb  = 13'(y);
        mcu_start  = 1'b1;
        @(posedge clk);
        #1;
        mcu_start = 1'b0;
        @(negedge clk);
        check("out_empty_fall", 64'(out_empty), 64'd0);
    endtask

    task automatic finish_mcu(output int cycles);
        cycles = 0;
        while (out_empty !== 1'b1 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        check("mcu_done_in_time", 64'(cycles < 3000), 64'd1);
        check("write_count", 64'(acc_cnt), 64'(exp_n));
        check("queue_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int cyc;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_empty", 64'(out_empty), 64'd1);
        check("rst_wr_valid", 64'(fb_wr_valid), 64'd0);
        check("rst_rd_en", 64'(buf_rd_en), 64'd0);
        check("rst_rd_addr", 64'(buf_rd_addr), 64'd0);
        check("rst_wr_addr", 64'(fb_wr_addr), 64'd0);
        check("rst_wr_data", 64'(fb_wr_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        start_mcu(1'b0, 64, 64, 0, 0, 0);
        finish_mcu(cyc);
        check("full_mcu_cycles", 64'(cyc <= FULL_MCU_CYCLES), 64'd1);

        start_mcu(1'b1, 20, 16, 1, 0, 0);
        finish_mcu(cyc);

        start_mcu(1'b0, 8, 5, 0, 0, 1);
        finish_mcu(cyc);

        start_mcu(1'b0, 8, 5, 1, 0, 0);
        finish_mcu(cyc);
        check("clipped_idle_cycles", 64'(cyc <= 3), 64'd1);

        start_mcu(1'b0, 64, 64, 0, 0, 2);
        finish_mcu(cyc);

        // Reset in the middle of an MCU: nothing further may be written.
        start_mcu(1'b0, 64, 64, 0, 0, 0);
        n = 0;
        while (acc_cnt < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_pixel10", 64'(acc_cnt >= 10), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_wr_valid", 64'(fb_wr_valid), 64'd0);
        check("midrst_out_empty", 64'(out_empty), 64'd1);
        repeat (20) @(negedge clk);

        start_mcu(1'b0, 64, 64, 0, 0, 1);
        finish_mcu(cyc);

        // Address wrap past 2^ADDR_W.
        start_mcu(1'b1, 65535, 65535, 2, 300, 1);
        finish_mcu(cyc);

        for (int k = 0; k < 10; k++) begin
            start_mcu(1'($urandom_range(0, 1)), $urandom_range(1, 48), $urandom_range(1, 48),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1);
            finish_mcu(cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
